next_pc_predictor: RTL
======================

// Module: next_pc_predictor
// PURPOSE
//  Fetch-stage next-PC generator: owns the PC register, predicts via a direct-mapped BTB with saturating counters,
//  trains from Execute, flags mispredicts and redirects. Sits between the instruction memory address and the E-stage branch unit.
// PARAMETERS
//  DATA_WIDTH   32           PC/target width
//  BTB_ENTRIES  16           BTB entries, power of 2, >=2; IDX_W=$clog2(BTB_ENTRIES)
//  CTR_BITS     2            saturating counter width, >=1; predict taken when MSB=1
//  RESET_PC     32'h0000_0000 PC value after reset
// PORTS
//  clk_i              in   1           clock
//  rst_i              in   1           synchronous active-high reset
//  StallF_i           in   1           hold PC (ignored when mispredict)
//  PCF_o              out  DATA_WIDTH  current fetch PC (registered)
//  PredictTakenF_o    out  1           BTB hit && counter MSB
//  PredictTargetF_o   out  DATA_WIDTH  BTB target for PCF_o (0 on miss)
//  BranchE_i          in   1           E-stage instr is conditional branch
//  JumpE_i            in   1           E-stage instr is JAL or JALR
//  JalrE_i            in   1           E-stage jump is JALR (target = ALUResultE_i)
//  PCSrcE_i           in   1           actual taken
//  PCE_i              in   DATA_WIDTH  PC of E-stage instr
//  PCTargetE_i        in   DATA_WIDTH  PC-relative target
//  ALUResultE_i       in   DATA_WIDTH  JALR target
//  PCPlus4E_i         in   DATA_WIDTH  fall-through correction
//  PredictTakenE_i    in   1           prediction carried to E
//  PredictTargetE_i   in   DATA_WIDTH  predicted target carried to E
//  MispredictE_o      out  1           combinational; flush F/D when high
//  BranchCnt_o        out  32          resolved branch/jump count (PERF_CNT_EN)
//  MispredCnt_o       out  32          mispredict count (PERF_CNT_EN)
// BEHAVIOUR
//  Index = PC[IDX_W+1:2]; tag = PC[DATA_WIDTH-1:IDX_W+2]; PC[1:0] ignored.
//  Lookup combinational from PCF_o same cycle; a same-cycle update to the same index is seen next cycle (read-old).
//  ActualTgt = JalrE_i ? ALUResultE_i : PCTargetE_i.
//  MispredictE_o = (Br|Jmp) ? (PredictTakenE_i!=PCSrcE_i || (PCSrcE_i && PredictTargetE_i!=ActualTgt))
//                           : PredictTakenE_i  (non-control instr predicted taken = alias).
//  PC next priority: rst_i -> RESET_PC; Mispredict -> (PCSrcE_i ? ActualTgt : PCPlus4E_i);
//   StallF_i -> hold; PredictTakenF_o -> PredictTargetF_o; else PCF_o+4. Latency: 1 cycle, PC registered.
//  Update (clock edge when BranchE_i|JumpE_i, no stall gating):
//   hit: target<=ActualTgt if taken; ctr sat-inc if taken else sat-dec (no wrap at 0 / all-ones).
//   miss & taken: allocate valid=1, tag, target=ActualTgt, ctr=weakly-taken (MSB=1, rest 0).
//   miss & not taken: no allocation.
//   alias (non-control, PredictTakenE_i): invalidate entry at PCE_i index if tag matches.
//  Jumps train like always-taken branches; no separate JALR handling beyond target source.
//  Reset: all valid<=0, ctr<=weakly-not-taken (MSB=0, rest 1), PCF_o<=RESET_PC, counters<=0;
//   reset mid-operation overrides any concurrent update/mispredict. Outputs during reset cycle follow state.
// CONFIGURATION
//  NEXT_PC_PERF_CNT_EN defined: BranchCnt_o +1 per resolved Br|Jmp, MispredCnt_o +1 per MispredictE_o;
//   both 32-bit, wrap at 2^32. Undefined: counter regs absent, both ports tied 0.
// STRUCTURE
//  Package next_pc_pkg: btb_entry_t {valid, tag, target, ctr}, CTR_WEAK_T/CTR_WEAK_NT constants,
//   functions ctr_inc/ctr_dec (saturating), idx_of/tag_of.
//  Sub-module btb_array: storage + read port + single write port + sync clear; top holds PC reg, mispredict, update policy.
// TESTING
//  1 Reset, no branches, 4 cycles -> PCF_o 0,4,8,C; PredictTakenF_o=0.
//  2 Taken branch PCE=0x10, target 0x40, predicted NT -> MispredictE_o=1, next PCF_o=0x40; later fetch of 0x10 -> PredictTakenF_o=1, target 0x40.
//  3 Same branch then NT twice (ctr 10->01->00) -> 1st: mispredict, PC<=PCPlus4E 0x14; 2nd fetch predicts NT, no mispredict.
//  4 JALR at 0x20, ALUResultE=0x80 then 0x90 -> 2nd resolve target mismatch, mispredict, PC<=0x90, BTB target updated.
//  5 Alias: 0x410 shares index with 0x10 (16 entries), tag differs -> no hit; non-control E with PredictTakenE_i=1 -> mispredict to PCPlus4E_i, entry invalidated.
//  6 StallF_i=1 with Mispredict -> redirect taken; rst_i mid-run -> PCF_o=RESET_PC, all BTB misses; PERF_CNT_EN counts match branch/mispredict totals.

Source files
------------

// File: rtl/next_pc_predictor_pkg.sv
// Shared types and helpers for the fetch next-PC predictor.
// BTB geometry lives here; entry and counter types are sized from it.
package next_pc_pkg;

   localparam int NPC_DATA_W   = 32;
   localparam int NPC_ENTRIES  = 16;
   localparam int NPC_CTR_BITS = 2;
   localparam int NPC_IDX_W    = $clog2(NPC_ENTRIES);
   localparam int NPC_TAG_W    = NPC_DATA_W - NPC_IDX_W - 2;

   typedef logic [NPC_DATA_W-1:0]   addr_t;
   typedef logic [NPC_IDX_W-1:0]    idx_t;
   typedef logic [NPC_TAG_W-1:0]    tag_t;
   typedef logic [NPC_CTR_BITS-1:0] ctr_t;

   // weakly taken = MSB set, rest clear; weakly not-taken is one below
   localparam ctr_t CTR_WEAK_T  = ctr_t'(1) << (NPC_CTR_BITS - 1);
   localparam ctr_t CTR_WEAK_NT = CTR_WEAK_T - ctr_t'(1);

   typedef struct packed {
      logic  valid;
      tag_t  tag;
      addr_t target;
      ctr_t  ctr;
   } btb_entry_t;

   function automatic ctr_t ctr_inc(input ctr_t c);
      return (c == '1) ? c : c + ctr_t'(1);
   endfunction

   function automatic ctr_t ctr_dec(input ctr_t c);
      return (c == '0) ? c : c - ctr_t'(1);
   endfunction

   function automatic idx_t idx_of(input addr_t pc);
      return pc[NPC_IDX_W+1:2];
   endfunction

   function automatic tag_t tag_of(input addr_t pc);
      return pc[NPC_DATA_W-1:NPC_IDX_W+2];
   endfunction

endpackage

// File: rtl/next_pc_predictor_if.sv
// Fetch/Execute bundle of the next-PC predictor.
// master = pipeline side, slave = predictor.
interface next_pc_predictor_if
   import next_pc_pkg::*;
#(
   parameter int DATA_WIDTH = NPC_DATA_W
) ();

   logic                  StallF_i;
   logic [DATA_WIDTH-1:0] PCF_o;
   logic                  PredictTakenF_o;
   logic [DATA_WIDTH-1:0] PredictTargetF_o;
   logic                  BranchE_i;
   logic                  JumpE_i;
   logic                  JalrE_i;
   logic                  PCSrcE_i;
   logic [DATA_WIDTH-1:0] PCE_i;
   logic [DATA_WIDTH-1:0] PCTargetE_i;
   logic [DATA_WIDTH-1:0] ALUResultE_i;
   logic [DATA_WIDTH-1:0] PCPlus4E_i;
   logic                  PredictTakenE_i;
   logic [DATA_WIDTH-1:0] PredictTargetE_i;
   logic                  MispredictE_o;
   logic [31:0]           BranchCnt_o;
   logic [31:0]           MispredCnt_o;

   modport master (
      output StallF_i, BranchE_i, JumpE_i,
      output JalrE_i, PCSrcE_i, PCE_i,
      output PCTargetE_i, ALUResultE_i,
      output PCPlus4E_i, PredictTakenE_i,
      output PredictTargetE_i,
      input  PCF_o, PredictTakenF_o,
      input  PredictTargetF_o, MispredictE_o,
      input  BranchCnt_o, MispredCnt_o
   );

   modport slave (
      input  StallF_i, BranchE_i, JumpE_i,
      input  JalrE_i, PCSrcE_i, PCE_i,
      input  PCTargetE_i, ALUResultE_i,
      input  PCPlus4E_i, PredictTakenE_i,
      input  PredictTargetE_i,
      output PCF_o, PredictTakenF_o,
      output PredictTargetF_o, MispredictE_o,
      output BranchCnt_o, MispredCnt_o
   );

endinterface

// File: rtl/next_pc_predictor_btb_array.sv
// Direct-mapped BTB storage: two async read ports, one write port.
// Synchronous clear invalidates every entry and wins over a write.
module btb_array
   import next_pc_pkg::*;
#(
   parameter int ENTRIES = NPC_ENTRIES
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  idx_t       rd_f_idx,
   output btb_entry_t rd_f_ent,
   input  idx_t       rd_e_idx,
   output btb_entry_t rd_e_ent,
   input  logic       we,
   input  idx_t       wr_idx,
   input  btb_entry_t wr_ent
);

   btb_entry_t mem [ENTRIES];

   assign rd_f_ent = mem[rd_f_idx];
   assign rd_e_ent = mem[rd_e_idx];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            mem[i] <= '{valid:  1'b0,
                        tag:    '0,
                        target: '0,
                        ctr:    CTR_WEAK_NT};
         end
      end else if (we) begin
         mem[wr_idx] <= wr_ent;
      end
   end

endmodule

// File: rtl/next_pc_predictor.sv
// Fetch-stage next-PC generator with BTB prediction and E-stage training.
// NEXT_PC_PERF_CNT_EN adds resolved-branch and mispredict counters.
module next_pc_predictor
   import next_pc_pkg::*;
#(
   parameter int DATA_WIDTH  = NPC_DATA_W,
   parameter int BTB_ENTRIES = NPC_ENTRIES,
   parameter int CTR_BITS    = NPC_CTR_BITS,
   parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
   input logic clk_i,
   input logic rst_i,
   next_pc_predictor_if.slave bus
);

   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] actual_tgt;
   logic [DATA_WIDTH-1:0] ptgt_f;
   btb_entry_t f_ent, e_ent, w_ent;
   logic hit_f, hit_e, pt_f;
   logic ctrl, taken, mispred, we;

   btb_array #(.ENTRIES(BTB_ENTRIES)) u_btb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .rd_f_idx (idx_of(pc_q)),
      .rd_f_ent (f_ent),
      .rd_e_idx (idx_of(bus.PCE_i)),
      .rd_e_ent (e_ent),
      .we       (we),
      .wr_idx   (idx_of(bus.PCE_i)),
      .wr_ent   (w_ent)
   );

   assign hit_f  = f_ent.valid &&
                   (f_ent.tag == tag_of(pc_q));
   assign pt_f   = hit_f && f_ent.ctr[CTR_BITS-1];
   assign ptgt_f = hit_f ? f_ent.target : '0;

   assign hit_e  = e_ent.valid &&
                   (e_ent.tag == tag_of(bus.PCE_i));
   assign ctrl   = bus.BranchE_i | bus.JumpE_i;
   assign taken  = bus.PCSrcE_i;

   assign actual_tgt = bus.JalrE_i ? bus.ALUResultE_i
                                   : bus.PCTargetE_i;

   // a non-control instr predicted taken is a BTB alias
   always_comb begin
      mispred = bus.PredictTakenE_i;
      if (ctrl) begin
         mispred = (bus.PredictTakenE_i != taken) ||
                   (taken &&
                    bus.PredictTargetE_i != actual_tgt);
      end
   end

   always_comb begin
      we    = 1'b0;
      w_ent = e_ent;
      if (ctrl) begin
         if (hit_e) begin
            we = 1'b1;
            if (taken) begin
               w_ent.ctr    = ctr_inc(e_ent.ctr);
               w_ent.target = actual_tgt;
            end else begin
               w_ent.ctr = ctr_dec(e_ent.ctr);
            end
         end else if (taken) begin
            we           = 1'b1;
            w_ent.valid  = 1'b1;
            w_ent.tag    = tag_of(bus.PCE_i);
            w_ent.target = actual_tgt;
            w_ent.ctr    = CTR_WEAK_T;
         end
      end else if (bus.PredictTakenE_i && hit_e) begin
         we          = 1'b1;
         w_ent.valid = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q <= RESET_PC;
      end else if (mispred) begin
         pc_q <= taken ? actual_tgt : bus.PCPlus4E_i;
      end else if (!bus.StallF_i) begin
         pc_q <= pt_f ? ptgt_f
                      : pc_q + DATA_WIDTH'(4);
      end
   end

   assign bus.PCF_o            = pc_q;
   assign bus.PredictTakenF_o  = pt_f;
   assign bus.PredictTargetF_o = ptgt_f;
   assign bus.MispredictE_o    = mispred;

`ifdef NEXT_PC_PERF_CNT_EN
   logic [31:0] br_cnt, mp_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         br_cnt <= '0;
         mp_cnt <= '0;
      end else begin
         if (ctrl)    br_cnt <= br_cnt + 32'd1;
         if (mispred) mp_cnt <= mp_cnt + 32'd1;
      end
   end

   assign bus.BranchCnt_o  = br_cnt;
   assign bus.MispredCnt_o = mp_cnt;
`else
   assign bus.BranchCnt_o  = '0;
   assign bus.MispredCnt_o = '0;
`endif

endmodule
